pipe_stage_reg: RTL

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and optional skid buffering. It replaces the fixed per-stage registers between IF/ID/EX/MEM/WB in the RISC-V core. The default configuration carries the MEM→WB bundle: RegWrite, ResultSrc, ALUResult, ReadData and Rd, 71 bits in total. Stalls come from the consumer's ready, and kills come from hazard/branch logic via flush.

---
 rtl/core_pipe_pkg.sv | 35 +++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/core_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pipe_pkg
// Purpose : Definitions shared by the pipeline stage registers and by the
//           stages that pack or unpack their payloads. This includes the stage
//           state encoding, the MEM->WB bundle width and the field offsets
//           inside that bundle.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package core_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // MEM->WB bundle, MSB->LSB: {ALUResult, ReadData, Rd, ResultSrc, RegWrite}
    localparam int MEMWB_W      = 71;
    localparam int MEMWB_CTRL_W = 2;

    localparam int MEMWB_REGWRITE_LSB  = 0;
    localparam int MEMWB_REGWRITE_W    = 1;
    localparam int MEMWB_RESULTSRC_LSB = 1;
    localparam int MEMWB_RESULTSRC_W   = 1;
    localparam int MEMWB_RD_LSB        = 2;
    localparam int MEMWB_RD_W          = 5;
    localparam int MEMWB_READDATA_LSB  = 7;
    localparam int MEMWB_READDATA_W    = 32;
    localparam int MEMWB_ALURESULT_LSB = 39;
    localparam int MEMWB_ALURESULT_W   = 32;

endpackage : core_pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Purpose : Pipeline stage register with a valid/ready handshake, a
//           synchronous flush and an optional two-entry skid buffer.
//           The low CTRL_W payload bits are control enables. They are
//           forced to zero whenever no payload is presented, so that a
//           bubble can never write architectural state.
// Ports   : clk        - rising-edge clock
//           rst_n      - asynchronous active-low reset
//           flush      - synchronous kill of held and incoming payloads
//           in_valid   - upstream payload available
//           in_ready   - stage accepts a payload this cycle
//           in_data    - upstream payload [DATA_W-1:0]
//           out_valid  - payload presented downstream
//           out_ready  - downstream consumes this cycle
//           out_data   - presented payload, control LSBs masked when idle
// Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // Ones in the CTRL_W least-significant bits. The shift-then-subtract form
    // also covers the CTRL_W == 0 and CTRL_W == DATA_W cases.
    localparam logic [DATA_W-1:0] CTRL_MASK = (DATA_W'(1) << CTRL_W) - DATA_W'(1);

    stage_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic              in_fire, out_fire;

    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : (main_q & ~CTRL_MASK);

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_q, skid_d;

            // The ready signal depends only on the state register, so there is
            // no combinational path from out_ready to in_ready.
            assign in_ready = (state_q != TWO);

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d = ONE;
                            main_d  = in_data;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_d = in_data;
                        end else if (in_fire) begin
                            state_d = TWO;
                            skid_d  = in_data;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        // in_ready is 0 in this state, so only a drain can occur.
                        if (out_fire) begin
                            state_d = ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                // Flush overrides every transition. An out_fire in the same
                // cycle has already been delivered.
                if (flush) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
                if (flush) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                end
            end
        end
    endgenerate

endmodule : pipe_stage_reg
`default_nettype wire
